arg_fetch_unit: RTL

Parametrised operand fetcher for the decode/execute front end. For each of `NUM_ARGS` operands it forms `register_value + immediate` and either keeps that sum as the operand or uses it as an address for a memory read through a request/response handshake. Operands are fetched in order, held in shadow registers, and published together with a one-cycle `done` pulse. It replaces the single-operand, step-gated loader and adds multi-operand sequencing, variable memory latency and flush.

---
 rtl/arg_fetch_pkg.sv | 17 +
 rtl/arg_fetch_unit_slot.sv | 59 +++++
 rtl/arg_fetch_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/arg_fetch_pkg.sv
// Shared state encoding and slot-index helpers for the operand fetcher.
package arg_fetch_pkg;

  typedef enum logic [2:0] {IDLE, ARG, WAIT, DONE, DRAIN} state_t;

  localparam int MIN_IDX_W = 1;

  // Operand index width; a single-operand unit still needs a 1-bit index.
  function automatic int idx_width(input int num_args);
    return (num_args > 1) ? $clog2(num_args) : MIN_IDX_W;
  endfunction

  function automatic int slot_lsb(input int slot, input int width);
    return slot * width;
  endfunction

endpackage

// File: rtl/arg_fetch_unit_slot.sv
// One operand: latched base/immediate, their sum, the shadow register and
// the committed output register.
module arg_slot #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] base_in,
  input  logic [WIDTH-1:0] imm_in,
  input  logic             is_mem_in,
  input  logic             cap_sum,
  input  logic             cap_mem,
  input  logic             commit,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] sum,
  output logic             is_mem,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] base_q;
  logic [WIDTH-1:0] imm_q;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] shadow_next;

  assign sum = base_q + imm_q;

  // The last operand is captured on the same edge as the commit, so the
  // committed value comes from the shadow's next value, not its current one.
  always_comb begin
    shadow_next = shadow;
    if (cap_sum) begin
      shadow_next = sum;
    end else if (cap_mem) begin
      shadow_next = mem_rdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      base_q <= '0;
      imm_q  <= '0;
      is_mem <= 1'b0;
      shadow <= '0;
      value  <= '0;
    end else begin
      if (load) begin
        base_q <= base_in;
        imm_q  <= imm_in;
        is_mem <= is_mem_in;
      end
      shadow <= shadow_next;
      if (commit) begin
        value <= shadow_next;
      end
    end
  end

endmodule

// File: rtl/arg_fetch_unit.sv
// Multi-operand fetcher: sequences NUM_ARGS operands, each either base+imm
// or a memory read at base+imm, and publishes them together with done.
module arg_fetch_unit #(
  parameter int WIDTH    = 16,
  parameter int NUM_ARGS = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      flush,
  input  logic [NUM_ARGS*WIDTH-1:0] immediate,
  input  logic [NUM_ARGS*WIDTH-1:0] register_value,
  input  logic [NUM_ARGS-1:0]       is_mem,
  output logic                      mem_req,
  output logic [WIDTH-1:0]          mem_addr,
  input  logic                      mem_ready,
  input  logic                      mem_rvalid,
  input  logic [WIDTH-1:0]          mem_rdata,
  output logic                      busy,
  output logic                      done,
  output logic [NUM_ARGS*WIDTH-1:0] arg_value
);

  import arg_fetch_pkg::*;

  localparam int IDX_W = idx_width(NUM_ARGS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ARGS - 1);

  state_t state, state_next;
  logic [IDX_W-1:0]    k, k_next;
  logic                load, cap_sum_en, cap_mem_en, advance, commit;
  logic [NUM_ARGS-1:0] sel, mem_lat;
  logic [WIDTH-1:0]    sums [NUM_ARGS];
  logic [WIDTH-1:0]    cur_sum;
  logic                cur_mem;

  for (genvar i = 0; i < NUM_ARGS; i++) begin : g_slot
    arg_slot #(.WIDTH(WIDTH)) u_slot (
      .clock     (clock),
      .reset     (reset),
      .load      (load),
      .base_in   (register_value[slot_lsb(i, WIDTH) +: WIDTH]),
      .imm_in    (immediate[slot_lsb(i, WIDTH) +: WIDTH]),
      .is_mem_in (is_mem[i]),
      .cap_sum   (sel[i] & cap_sum_en),
      .cap_mem   (sel[i] & cap_mem_en),
      .commit    (commit),
      .mem_rdata (mem_rdata),
      .sum       (sums[i]),
      .is_mem    (mem_lat[i]),
      .value     (arg_value[slot_lsb(i, WIDTH) +: WIDTH])
    );
  end

  // Decoded operand select; keeps non-power-of-two NUM_ARGS in range.
  always_comb begin
    sel     = '0;
    cur_sum = '0;
    cur_mem = 1'b0;
    for (int i = 0; i < NUM_ARGS; i++) begin
      if (k == IDX_W'(i)) begin
        sel[i]  = 1'b1;
        cur_sum = sums[i];
        cur_mem = mem_lat[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      k     <= '0;
    end else begin
      state <= state_next;
      k     <= k_next;
    end
  end

  // A flush coinciding with the response means nothing is left to drain.
  always_comb begin
    state_next = state;
    k_next     = k;
    load       = 1'b0;
    cap_sum_en = 1'b0;
    cap_mem_en = 1'b0;
    advance    = 1'b0;
    mem_req    = 1'b0;
    mem_addr   = '0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          k_next     = '0;
          state_next = ARG;
        end
      end
      ARG: begin
        if (flush) begin
          state_next = IDLE;
        end else if (!cur_mem) begin
          cap_sum_en = 1'b1;
          advance    = 1'b1;
        end else begin
          mem_req  = 1'b1;
          mem_addr = cur_sum;
          if (mem_ready) state_next = WAIT;
        end
      end
      WAIT: begin
        if (flush) begin
          state_next = mem_rvalid ? IDLE : DRAIN;
        end else if (mem_rvalid) begin
          cap_mem_en = 1'b1;
          advance    = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      DRAIN:   if (mem_rvalid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (advance) begin
      if (k == LAST_IDX) begin
        state_next = DONE;
      end else begin
        k_next     = k + IDX_W'(1);
        state_next = ARG;
      end
    end
  end

  assign commit = (state_next == DONE);
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

endmodule
